// File: rtl/lfsr_noise_gen_if.sv
// LFSR noise generator bus: seed load request/accept and packed output word handshake.
// Latency: none, wires only.
// Backpressure: out_valid/out_ready handshake; seed_ready is high whenever the block is out of reset.
// Ports: seed_valid/seed_data/seed_ready (seed load), out_valid/out_ready/out_data (packed noise word).
interface lfsr_noise_gen_if #(
    parameter int WIDTH    = 16,
    parameter int OUT_BITS = 8
);
    logic                seed_valid;
    logic [WIDTH-1:0]    seed_data;
    logic                seed_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;

    // master: the generator itself
    modport master (
        input  seed_valid,
        input  seed_data,
        output seed_ready,
        output out_valid,
        input  out_ready,
        output out_data
    );

    // slave: whoever seeds the generator and consumes its words
    modport slave (
        output seed_valid,
        output seed_data,
        input  seed_ready,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/lfsr_noise_gen.sv
// LFSR noise generator (Galois or Fibonacci) with LSB-first packing of serial bits into words.
// Latency: a completed word appears on out_data/out_valid at the edge of its last step.
// Backpressure: one held word plus one full collector; beyond that, stepping stalls until out_ready.
// Ports: clk, rst_n (async active-low), en (step enable), bus (seed load + output word),
//        noise (state[0], registered), period_pulse (one cycle per 2^WIDTH-1 steps).
module lfsr_noise_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               MODE     = 0,
    parameter int               OUT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    lfsr_noise_gen_if.master      bus,
    output logic                  noise,
    output logic                  period_pulse
);

    localparam int               BCW      = $clog2(OUT_BITS + 1);
    localparam logic [BCW-1:0]   BC_FULL  = BCW'(OUT_BITS);
    localparam logic [BCW-1:0]   BC_LAST  = BCW'(OUT_BITS - 1);
    // counter value whose next step completes a full period of 2^WIDTH-1 steps
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]    state, state_nxt, step_val;
    logic [WIDTH-1:0]    step_cnt, step_cnt_nxt;
    logic [OUT_BITS-1:0] coll, coll_nxt, coll_ins;
    logic [BCW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [OUT_BITS-1:0] out_data_q, out_data_nxt;
    logic                out_valid_q, out_valid_nxt;
    logic                pulse_q, pulse_nxt;
    logic                noise_q;

    logic                seed_acc;
    logic                coll_full;
    logic                slot_free;
    logic                stall;
    logic                state_zero;
    logic                do_step;
    logic                ser_bit;

    generate
        if (MODE == 1) begin : g_fib
            assign step_val = {^(state & TAPS), state[WIDTH-1:1]};
        end else begin : g_gal
            assign step_val = (state >> 1) ^ (state[0] ? TAPS : {WIDTH{1'b0}});
        end
    endgenerate

    // Reset is the only thing that can refuse a seed.
    assign bus.seed_ready = rst_n;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign noise          = noise_q;
    assign period_pulse   = pulse_q;

    always_comb begin
        seed_acc   = bus.seed_valid;
        coll_full  = (bit_cnt == BC_FULL);
        // the output register can take a word this cycle if empty or being drained now
        slot_free  = !out_valid_q || bus.out_ready;
        stall      = coll_full && !slot_free;
        state_zero = (state == '0);
        do_step    = en && !seed_acc && !stall && !state_zero;
        ser_bit    = state[0];
        // collector bits at and above bit_cnt are always zero, so OR inserts the new bit
        coll_ins   = coll | (OUT_BITS'(ser_bit) << bit_cnt);

        state_nxt     = state;
        step_cnt_nxt  = step_cnt;
        coll_nxt      = coll;
        bit_cnt_nxt   = bit_cnt;
        out_data_nxt  = out_data_q;
        out_valid_nxt = out_valid_q && !bus.out_ready;
        pulse_nxt     = 1'b0;

        if (seed_acc) begin
            // a seed load discards everything in flight, including a word being handed off
            state_nxt     = (bus.seed_data == '0) ? SEED : bus.seed_data;
            step_cnt_nxt  = '0;
            coll_nxt      = '0;
            bit_cnt_nxt   = '0;
            out_valid_nxt = 1'b0;
        end else begin
            if (state_zero) begin
                state_nxt = SEED;
            end else if (do_step) begin
                state_nxt = step_val;
            end

            // a word parked in the collector moves out as soon as the slot frees
            if (coll_full && slot_free) begin
                out_data_nxt  = coll;
                out_valid_nxt = 1'b1;
                coll_nxt      = '0;
                bit_cnt_nxt   = '0;
            end

            if (do_step) begin
                if (step_cnt == CNT_LAST) begin
                    step_cnt_nxt = '0;
                    pulse_nxt    = 1'b1;
                end else begin
                    step_cnt_nxt = step_cnt + 1'b1;
                end

                if (coll_full) begin
                    // collector was just emptied above; this bit starts the next word
                    coll_nxt    = OUT_BITS'(ser_bit);
                    bit_cnt_nxt = BCW'(1);
                end else if (bit_cnt == BC_LAST) begin
                    if (slot_free) begin
                        out_data_nxt  = coll_ins;
                        out_valid_nxt = 1'b1;
                        coll_nxt      = '0;
                        bit_cnt_nxt   = '0;
                    end else begin
                        coll_nxt    = coll_ins;
                        bit_cnt_nxt = BC_FULL;
                    end
                end else begin
                    coll_nxt    = coll_ins;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEED;
            step_cnt    <= '0;
            coll        <= '0;
            bit_cnt     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pulse_q     <= 1'b0;
            noise_q     <= SEED[0];
        end else begin
            state       <= state_nxt;
            step_cnt    <= step_cnt_nxt;
            coll        <= coll_nxt;
            bit_cnt     <= bit_cnt_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
            pulse_q     <= pulse_nxt;
            noise_q     <= state_nxt[0];
        end
    end

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Bench for lfsr_noise_gen: Galois (WIDTH=4, TAPS=C) and Fibonacci (WIDTH=4, TAPS=3) instances.
// Expected words come from a bench-side LFSR model pushed into a queue; a negedge monitor pops on handshake.
// Clock period 10; inputs change 1 time unit after the rising edge, outputs are sampled there or at negedge.
module tb_lfsr_noise_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, en_a, noise_a, pulse_a;
    logic rst_n_b, en_b, noise_b, pulse_b;

    lfsr_noise_gen_if #(.WIDTH(4), .OUT_BITS(4)) bus_a ();
    lfsr_noise_gen_if #(.WIDTH(4), .OUT_BITS(4)) bus_b ();

    lfsr_noise_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0), .OUT_BITS(4)) u_a (
        .clk          (clk),
        .rst_n        (rst_n_a),
        .en           (en_a),
        .bus          (bus_a),
        .noise        (noise_a),
        .period_pulse (pulse_a)
    );

    lfsr_noise_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1), .OUT_BITS(4)) u_b (
        .clk          (clk),
        .rst_n        (rst_n_b),
        .en           (en_b),
        .bus          (bus_b),
        .noise        (noise_b),
        .period_pulse (pulse_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] m_state, m_coll, m_last_word, mon_w;
    int         m_nbits, m_cnt;

    logic [3:0] gal_seq [16] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gal_next(input logic [3:0] s);
        return (s >> 1) ^ (s[0] ? 4'hC : 4'h0);
    endfunction

    function automatic logic [3:0] fib_next(input logic [3:0] s);
        return {^(s & 4'h3), s[3:1]};
    endfunction

    task automatic model_clear(input logic [3:0] s);
        m_state = s;
        m_coll  = '0;
        m_nbits = 0;
        m_cnt   = 0;
    endtask

    // one Galois step of the reference: collect the serial bit, push completed words
    task automatic model_step();
        m_coll[m_nbits] = m_state[0];
        m_nbits++;
        if (m_nbits == 4) begin
            exp_q.push_back(m_coll);
            m_last_word = m_coll;
            m_coll  = '0;
            m_nbits = 0;
        end
        m_state = gal_next(m_state);
        m_cnt   = (m_cnt == 14) ? 0 : m_cnt + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every accepted word must match the oldest expected one
    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed word %0h, expected none pending", bus_a.out_data);
            end
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                chk("sb_word", bus_a.out_data, mon_w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int distinct;
        logic [15:0] seen;
        logic [3:0]  f;

        rst_n_a = 1'b1; rst_n_b = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        bus_a.seed_valid = 1'b0; bus_a.seed_data = '0; bus_a.out_ready = 1'b1;
        bus_b.seed_valid = 1'b0; bus_b.seed_data = '0; bus_b.out_ready = 1'b1;
        m_last_word = '0;
        model_clear(4'h1);

        // asynchronous reset before any clock edge
        #2;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        #1;
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_out_data", bus_a.out_data, 4'h0);
        chk("rst_pulse", pulse_a, 1'b0);
        chk("rst_seed_ready", bus_a.seed_ready, 1'b0);
        chk("rst_noise", noise_a, 1'b1);
        chk("rst_state", u_a.state, 4'h1);
        chk("rst_step_cnt", u_a.step_cnt, 4'h0);
        chk("rst_noise_b", noise_b, 1'b1);

        tick();
        tick();
        rst_n_a = 1'b1;
        en_a    = 1'b1;
        #1;
        chk("seed_ready_out_of_rst", bus_a.seed_ready, 1'b1);

        // full Galois period with free-running consumer
        for (int i = 0; i < 16; i++) begin
            tick();
            model_step();
            chk("gal_state", u_a.state, gal_seq[i]);
            chk("gal_noise", noise_a, gal_seq[i][0]);
            chk("gal_pulse", pulse_a, (i == 14));
            if (i == 3) begin
                chk("word0_valid", bus_a.out_valid, 1'b1);
                chk("word0_data", bus_a.out_data, 4'h9);
            end
            if (i == 7) chk("word1_data", bus_a.out_data, 4'h5);
            if (i == 11) chk("word2_data", bus_a.out_data, 4'hF);
        end

        // two bits of a partial word, then a zero seed: SEED substituted, partial discarded
        for (int i = 0; i < 2; i++) begin
            tick();
            model_step();
        end
        bus_a.seed_valid = 1'b1;
        bus_a.seed_data  = 4'h0;
        tick();
        bus_a.seed_valid = 1'b0;
        model_clear(4'h1);
        chk("seed0_state", u_a.state, 4'h1);
        chk("seed0_out_valid", bus_a.out_valid, 1'b0);
        chk("seed0_step_cnt", u_a.step_cnt, 4'h0);
        chk("seed0_sb_empty", exp_q.size(), 0);

        // consumer stops: one word held, collector fills, then everything freezes
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            model_step();
        end
        for (int i = 0; i < 3; i++) tick();
        chk("stall_state", u_a.state, m_state);
        chk("stall_step_cnt", u_a.step_cnt, m_cnt);
        chk("stall_noise", noise_a, m_state[0]);
        chk("stall_out_valid", bus_a.out_valid, 1'b1);
        chk("stall_out_data", bus_a.out_data, 4'h9);
        chk("stall_sb_depth", exp_q.size(), 2);

        // release: held word then parked word drain in order
        en_a = 1'b0;
        bus_a.out_ready = 1'b1;
        tick();
        chk("release_next_word", bus_a.out_data, 4'h5);
        tick();
        chk("release_out_valid", bus_a.out_valid, 1'b0);
        chk("release_sb_empty", exp_q.size(), 0);

        // word completes on the same edge the held word is taken: no bubble
        en_a = 1'b1;
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            model_step();
        end
        bus_a.out_ready = 1'b1;
        tick();
        model_step();
        chk("nobubble_valid", bus_a.out_valid, 1'b1);
        chk("nobubble_data", bus_a.out_data, m_last_word);
        en_a = 1'b0;
        tick();
        tick();
        chk("nobubble_sb_empty", exp_q.size(), 0);

        // explicit seed value
        bus_a.seed_valid = 1'b1;
        bus_a.seed_data  = 4'hA;
        tick();
        bus_a.seed_valid = 1'b0;
        model_clear(4'hA);
        chk("seedA_state", u_a.state, 4'hA);
        chk("seedA_out_valid", bus_a.out_valid, 1'b0);
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            model_step();
            chk("seedA_walk", u_a.state, m_state);
        end
        chk("pre_rst_out_data", bus_a.out_data, 4'hA);

        // asynchronous reset mid-cycle, mid-word
        #3;
        rst_n_a = 1'b0;
        #1;
        chk("arst_out_valid", bus_a.out_valid, 1'b0);
        chk("arst_out_data", bus_a.out_data, 4'h0);
        chk("arst_pulse", pulse_a, 1'b0);
        chk("arst_seed_ready", bus_a.seed_ready, 1'b0);
        chk("arst_noise", noise_a, 1'b1);
        chk("arst_state", u_a.state, 4'h1);
        chk("arst_step_cnt", u_a.step_cnt, 4'h0);
        exp_q.delete();
        model_clear(4'h1);
        tick();
        chk("arst_hold_state", u_a.state, 4'h1);
        rst_n_a = 1'b1;
        tick();
        model_step();
        chk("arst_first_step", u_a.state, m_state);
        chk("arst_first_cnt", u_a.step_cnt, m_cnt);
        en_a = 1'b0;

        // Fibonacci instance: one full maximal-length period
        rst_n_b = 1'b1;
        en_b    = 1'b1;
        f        = 4'h1;
        seen     = '0;
        pulses   = 0;
        distinct = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            f = fib_next(f);
            chk("fib_state", u_b.state, f);
            chk("fib_nonzero", (u_b.state != 4'h0), 1'b1);
            if (u_b.state !== 4'h0 && !seen[u_b.state]) begin
                seen[u_b.state] = 1'b1;
                distinct++;
            end
            if (pulse_b === 1'b1) pulses++;
        end
        en_b = 1'b0;
        chk("fib_distinct", distinct, 15);
        chk("fib_pulses", pulses, 1);
        chk("fib_return", u_b.state, 4'h1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
